mux_scan_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. It is the successor to the fixed 8-bit 2:1 combinational mux.
- Manual mode: an external select picks the channel.
- Scan mode: an internal prescaled counter steps through all channels in round-robin order.
Sits between the CPU/peripheral data sources and the display/debug output path. It feeds one selected word plus a channel index and an update strobe.

---
 rtl/mux_scan_n_pkg.sv | 20 ++
 rtl/mux_scan_n_prescaler.sv | 30 +++
 rtl/mux_scan_n.sv | 68 ++++++
 tb/tb_mux_scan_n.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux_scan_n_pkg.sv
// Shared constants and helpers for the registered N-channel scan multiplexer.
package mux_scan_n_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_n_prescaler.sv
// Scan step prescaler: counts enabled cycles and ticks on the last one of each DIV-cycle dwell.
module scan_prescaler
  import mux_scan_n_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || tick) cnt <= '0;
      else             cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer with manual select or round-robin scan.
module mux_scan_n
  import mux_scan_n_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 8,
  parameter int DIV = 1,
  localparam int SW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  din,
  output logic [W-1:0]    dout,
  output logic [SW-1:0]   ch,
  output logic            upd
);

  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  logic          tick;
  logic [SW-1:0] ch_nxt;

  // Out-of-range indices (N not a power of two) select zero.
  function automatic logic [W-1:0] pick(input logic [SW-1:0] k, input logic [N*W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (k == SW'(i)) r = d[i*W +: W];
    end
    return r;
  endfunction

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (mode == MODE_MANUAL),
    .tick  (tick)
  );

  always_comb begin
    ch_nxt = ch;
    if (mode == MODE_MANUAL) begin
      ch_nxt = sel;
    end else if (tick) begin
      ch_nxt = (ch >= LAST_CH) ? '0 : ch + SW'(1);
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
      ch   <= '0;
      upd  <= 1'b0;
    end else if (en) begin
      dout <= pick(ch_nxt, din);
      ch   <= ch_nxt;
      upd  <= (ch_nxt != ch);
    end else begin
      upd  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a 4-channel DIV=3 instance and a 3-channel DIV=1 instance.
module tb_mux_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, W=8, DIV=3
  logic        rst_a, en_a, mode_a;
  logic [1:0]  sel_a;
  logic [31:0] din_a;
  logic [7:0]  dout_a;
  logic [1:0]  ch_a;
  logic        upd_a;

  // Instance B: N=3, W=8, DIV=1
  logic        rst_b, en_b, mode_b;
  logic [1:0]  sel_b;
  logic [23:0] din_b;
  logic [7:0]  dout_b;
  logic [1:0]  ch_b;
  logic        upd_b;

  mux_scan_n #(.W(8), .N(4), .DIV(3)) dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .mode(mode_a), .sel(sel_a),
    .din(din_a), .dout(dout_a), .ch(ch_a), .upd(upd_a)
  );

  mux_scan_n #(.W(8), .N(3), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .mode(mode_b), .sel(sel_b),
    .din(din_b), .dout(dout_b), .ch(ch_b), .upd(upd_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] d, input logic [1:0] c, input logic u);
    check_eq({tag, ".dout"}, {24'h0, dout_a}, {24'h0, d});
    check_eq({tag, ".ch"},   {30'h0, ch_a},   {30'h0, c});
    check_eq({tag, ".upd"},  {31'h0, upd_a},  {31'h0, u});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] d, input logic [1:0] c, input logic u);
    check_eq({tag, ".dout"}, {24'h0, dout_b}, {24'h0, d});
    check_eq({tag, ".ch"},   {30'h0, ch_b},   {30'h0, c});
    check_eq({tag, ".upd"},  {31'h0, upd_b},  {31'h0, u});
  endtask

  // Expected scan trace after reset release (DIV=3, din = 44,33,22,11)
  logic [7:0] exp_d [15] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33,
                             8'h44, 8'h44, 8'h44, 8'h11, 8'h11, 8'h11, 8'h22};
  logic [1:0] exp_c [15] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                             2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
  logic       exp_u [15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b1; sel_a = 2'd0;
    din_a = {8'h44, 8'h33, 8'h22, 8'h11};
    rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b0; sel_b = 2'd0;
    din_b = {8'h33, 8'h22, 8'h11};

    // Reset held for two edges with en=1, mode=scan
    step();
    step();
    chk_a("reset", 8'h00, 2'd0, 1'b0);

    // Scan trace including wrap from ch=3 back to ch=0
    rst_a = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_a($sformatf("scan%0d", i), exp_d[i], exp_c[i], exp_u[i]);
    end

    // Freeze mid-dwell with prescaler at 1
    step();
    chk_a("dwell_p1", 8'h22, 2'd1, 1'b0);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a($sformatf("hold%0d", i), 8'h22, 2'd1, 1'b0);
    end
    en_a = 1'b1;
    step();
    chk_a("reen0", 8'h22, 2'd1, 1'b0);
    step();
    chk_a("reen_step", 8'h33, 2'd2, 1'b1);
    // upd must not stretch when en drops right after a step
    en_a = 1'b0;
    step();
    chk_a("nostretch", 8'h33, 2'd2, 1'b0);
    en_a = 1'b1;

    // Reset mid-scan at ch=2, then full dwell on ch=0 with live data tracking
    step();
    chk_a("pre_rst", 8'h33, 2'd2, 1'b0);
    rst_a = 1'b0;
    step();
    chk_a("mid_rst", 8'h00, 2'd0, 1'b0);
    rst_a = 1'b1;
    step();
    chk_a("post_rst0", 8'h11, 2'd0, 1'b0);
    din_a[7:0] = 8'h55;
    step();
    chk_a("live_track", 8'h55, 2'd0, 1'b0);
    din_a[7:0] = 8'h11;
    step();
    chk_a("post_rst_step", 8'h22, 2'd1, 1'b1);

    // Manual mode: prime sel=0, then 0,2,2,1
    mode_a = 1'b0; sel_a = 2'd0;
    step();
    chk_a("man_prime", 8'h11, 2'd0, 1'b1);
    sel_a = 2'd0; step(); chk_a("man_s0", 8'h11, 2'd0, 1'b0);
    sel_a = 2'd2; step(); chk_a("man_s2", 8'h33, 2'd2, 1'b1);
    sel_a = 2'd2; step(); chk_a("man_s2b", 8'h33, 2'd2, 1'b0);
    sel_a = 2'd1; step(); chk_a("man_s1", 8'h22, 2'd1, 1'b1);

    // Manual -> scan: first step a full DIV cycles later
    mode_a = 1'b1;
    step(); chk_a("m2s0", 8'h22, 2'd1, 1'b0);
    step(); chk_a("m2s1", 8'h22, 2'd1, 1'b0);
    step(); chk_a("m2s_step", 8'h33, 2'd2, 1'b1);
    // Scan -> manual takes effect on the next edge
    mode_a = 1'b0; sel_a = 2'd3;
    step(); chk_a("s2m", 8'h44, 2'd3, 1'b1);

    // Instance B: out-of-range select, then DIV=1 scanning
    step();
    chk_b("b_reset", 8'h00, 2'd0, 1'b0);
    rst_b = 1'b1; mode_b = 1'b0; sel_b = 2'd3;
    step(); chk_b("b_oor", 8'h00, 2'd3, 1'b1);
    step(); chk_b("b_oor_hold", 8'h00, 2'd3, 1'b0);
    mode_b = 1'b1;
    step(); chk_b("b_wrap", 8'h11, 2'd0, 1'b1);
    step(); chk_b("b_s1", 8'h22, 2'd1, 1'b1);
    step(); chk_b("b_s2", 8'h33, 2'd2, 1'b1);
    step(); chk_b("b_s0", 8'h11, 2'd0, 1'b1);
    mode_b = 1'b0; sel_b = 2'd2;
    step(); chk_b("b_man2", 8'h33, 2'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
